// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller: state encoding,
// select-code width and the counter-width helper.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    localparam int SEL_W = 3;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_scan_prescaler.sv
// Dwell counter for the scan controller: counts 0..DIV-1 per slot, flags the
// slot's last cycle and looks ahead at whether the coming cycle is blanked.
module scan_prescaler
    import decoder_scan_pkg::*;
#(
    parameter int DIV   = 16,
    parameter int BLANK = 2,
    localparam int CNT_W = clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             active_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             slot_end_o,
    output logic             in_blank_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: held at zero while idle or stopped, wraps at the slot end.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = CNT_ZERO;
        end else if (!active_i) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign slot_end_o = active_i && (cnt_q == CNT_LAST);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank_o = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK);
            assign in_blank_o = (cnt_d < BLANK_V);
        end
    endgenerate

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving a 3-to-8 decoder select/enable with blanking gaps
// and per-slot masking. Define SCAN_DIR_EN to add the dir (scan direction) input.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DIV       = 16,
    parameter int BLANK     = 2,
    parameter int NUM_SLOTS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [7:0]       mask,
`ifdef SCAN_DIR_EN
    input  logic             dir,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             slot_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(DIV - 2);
    localparam logic [SEL_W-1:0] SEL_ZERO = 3'd0;
    localparam logic [SEL_W-1:0] SEL_ONE  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SLOTS - 1);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             mask_q, mask_d;
    logic             dir_q, dir_d;
    logic             en_q, en_d;
    logic             slot_start_q, slot_start_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;

    logic             active_s;
    logic [CNT_W-1:0] cnt_s;
    logic             slot_end_s;
    logic             in_blank_s;
    logic             last_nxt_s;
    logic             dir_s;
    logic [SEL_W-1:0] sel_up_s;
    logic [SEL_W-1:0] sel_dn_s;
    logic [SEL_W-1:0] frame_slot_s;

`ifdef SCAN_DIR_EN
    assign dir_s = dir;
`else
    assign dir_s = 1'b0;
`endif

    assign active_s = (state_q != ST_IDLE);
    // Next cycle is the slot's last one exactly when the counter sits one below it.
    assign last_nxt_s = active_s && (cnt_s == CNT_PEN);
    assign sel_up_s   = (sel_q == SEL_LAST) ? SEL_ZERO : (sel_q + SEL_ONE);
    assign sel_dn_s   = (sel_q == SEL_ZERO) ? SEL_LAST : (sel_q - SEL_ONE);

    scan_prescaler #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .active_i   (active_s),
        .cnt_o      (cnt_s),
        .slot_end_o (slot_end_s),
        .in_blank_o (in_blank_s)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        mask_d       = mask_q;
        dir_d        = dir_q;
        en_d         = 1'b0;
        slot_start_d = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = 1'b0;
        frame_slot_s = SEL_LAST;
        if (!run) begin
            state_d = ST_IDLE;
            sel_d   = SEL_ZERO;
            mask_d  = 1'b0;
            dir_d   = 1'b0;
        end else begin
            busy_d  = 1'b1;
            state_d = in_blank_s ? ST_BLANK : ST_ON;
            if (state_q == ST_IDLE) begin
                slot_start_d = 1'b1;
                dir_d        = dir_s;
                sel_d        = dir_s ? SEL_LAST : SEL_ZERO;
            end else if (slot_end_s) begin
                slot_start_d = 1'b1;
                dir_d        = dir_s;
                sel_d        = dir_s ? sel_dn_s : sel_up_s;
            end else begin
                slot_start_d = 1'b0;
            end
            // The slot's mask bit is frozen as the slot begins.
            if (slot_start_d) begin
                mask_d = mask[sel_d];
            end else begin
                mask_d = mask_q;
            end
            frame_slot_s = dir_d ? SEL_ZERO : SEL_LAST;
            en_d         = !in_blank_s && mask_d;
            frame_done_d = last_nxt_s && (sel_d == frame_slot_s);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_ZERO;
            mask_q       <= 1'b0;
            dir_q        <= 1'b0;
            en_q         <= 1'b0;
            slot_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            dir_q        <= dir_d;
            en_q         <= en_d;
            slot_start_q <= slot_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign slot_start = slot_start_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: directed vector table, corner
// sequences and randomized run/mask/reset traffic against a slot-level model.
module tb_decoder_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int NS    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [7:0] mask;
    logic       dir;

    logic [2:0] sel_a, sel_b;
    logic       en_a, ss_a, fd_a, busy_a;
    logic       en_b, ss_b, fd_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .NUM_SLOTS(NS)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
`ifdef SCAN_DIR_EN
        .dir        (dir),
`endif
        .sel        (sel_a),
        .en         (en_a),
        .slot_start (ss_a),
        .frame_done (fd_a),
        .busy       (busy_a)
    );

    decoder_scan_ctrl #(.DIV(2), .BLANK(0), .NUM_SLOTS(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
`ifdef SCAN_DIR_EN
        .dir        (dir),
`endif
        .sel        (sel_b),
        .en         (en_b),
        .slot_start (ss_b),
        .frame_done (fd_b),
        .busy       (busy_b)
    );

    // Slot-level reference: a phase within the dwell and a slot index.
    bit         m_active = 1'b0;
    int         m_ph     = 0;
    int         m_slot   = 0;
    bit         m_mbit   = 1'b0;
    bit         m_dir    = 1'b0;
    logic [2:0] prev_sel = 3'd0;

    typedef struct {
        bit         run;
        logic [7:0] mask;
        logic [2:0] sel;
        bit         en;
        bit         ss;
        bit         fd;
        bit         busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [7:0] mk, input bit d);
        if (!r) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_ph     = 0;
            m_dir    = d;
            m_slot   = d ? NS - 1 : 0;
            m_mbit   = mk[m_slot];
        end else if (m_ph == DIV - 1) begin
            m_ph   = 0;
            m_dir  = d;
            m_slot = d ? (m_slot + NS - 1) % NS : (m_slot + 1) % NS;
            m_mbit = mk[m_slot];
        end else begin
            m_ph++;
        end
    endtask

    task automatic model_check();
        logic [6:0] got;
        logic [6:0] exp;
        logic [2:0] es;
        bit         ee, es_s, ef;
        es   = m_active ? 3'(m_slot) : 3'd0;
        ee   = m_active && (m_ph >= BLANK) && m_mbit;
        es_s = m_active && (m_ph == 0);
        ef   = m_active && (m_ph == DIV - 1) && (m_slot == (m_dir ? 0 : NS - 1));
        got  = {sel_a, en_a, ss_a, fd_a, busy_a};
        exp  = {es, ee, es_s, ef, m_active};
        chk("scan_out", int'(got), int'(exp));
        if (sel_a != prev_sel) begin
            chk("en_low_on_sel_change", int'(en_a), 0);
        end
        prev_sel = sel_a;
    endtask

    task automatic cyc(input bit r, input logic [7:0] mk, input bit d);
        run  = r;
        mask = mk;
        dir  = d;
        @(posedge clk);
        model_step(r, mk, d);
        #1;
        model_check();
    endtask

    task automatic async_rst();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clear", int'({sel_a, en_a, ss_a, fd_a, busy_a}), 0);
        m_active = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int first_fd, second_fd, en_cnt, en_even, guard;
        bit r, dd;
        logic [7:0] mk;

        rst_n = 1'b0;
        run   = 1'b0;
        mask  = 8'h00;
        dir   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({sel_a, en_a, ss_a, fd_a, busy_a}), 0);
        rst_n = 1'b1;

        tbl[0]  = '{1'b0, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'hFF, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'hFF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'h00, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'hFF, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 14; i++) begin
            run  = tbl[i].run;
            mask = tbl[i].mask;
            dir  = 1'b0;
            @(posedge clk);
            model_step(tbl[i].run, tbl[i].mask, 1'b0);
            #1;
            chk($sformatf("vec%0d", i),
                int'({sel_a, en_a, ss_a, fd_a, busy_a}),
                int'({tbl[i].sel, tbl[i].en, tbl[i].ss, tbl[i].fd, tbl[i].busy}));
            prev_sel = sel_a;
        end

        // frame_done lands on cycle 32 after start, then every 32 cycles.
        cyc(1'b0, 8'hFF, 1'b0);
        first_fd  = 0;
        second_fd = 0;
        for (int c = 1; c <= 100; c++) begin
            cyc(1'b1, 8'hFF, 1'b0);
            if (fd_a && first_fd == 0) first_fd = c;
            else if (fd_a && second_fd == 0) second_fd = c;
            if (second_fd != 0) break;
        end
        chk("frame_done_first", first_fd, 32);
        chk("frame_done_second", second_fd, 64);

        // Stop at sel=5, cnt=2, then restart.
        guard = 0;
        while (!(m_active && m_slot == 5 && m_ph == 2) && guard < 200) begin
            cyc(1'b1, 8'hFF, 1'b0);
            guard++;
        end
        chk("stop_point_reached", int'(guard < 200), 1);
        cyc(1'b0, 8'hFF, 1'b0);
        chk("stop_idle", int'({sel_a, en_a, fd_a, busy_a}), 0);
        cyc(1'b1, 8'hFF, 1'b0);
        chk("restart_slot_start", int'({sel_a, ss_a, en_a}), int'({3'd0, 1'b1, 1'b0}));
        cyc(1'b1, 8'hFF, 1'b0);
        chk("restart_latency_en", int'(en_a), 1);

        // Alternating mask: en only in odd slots, 3 cycles each.
        cyc(1'b0, 8'hAA, 1'b0);
        en_cnt  = 0;
        en_even = 0;
        for (int c = 0; c < 64; c++) begin
            cyc(1'b1, 8'hAA, 1'b0);
            if (en_a) en_cnt++;
            if (en_a && !sel_a[0]) en_even++;
        end
        chk("mask_aa_en_cycles", en_cnt, 24);
        chk("mask_aa_even_en", en_even, 0);

        // All slots masked: pulses continue, en never rises.
        en_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b1, 8'h00, 1'b0);
            if (en_a) en_cnt++;
        end
        chk("mask_00_en_cycles", en_cnt, 0);

        // Asynchronous reset mid-slot, then idle until run is sampled.
        async_rst();
        cyc(1'b0, 8'hFF, 1'b0);
        cyc(1'b0, 8'hFF, 1'b0);
        chk("post_reset_idle", int'(busy_a), 0);
        cyc(1'b1, 8'hFF, 1'b0);

        // Three-slot instance: DIV=2, BLANK=0.
        cyc(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 13; i++) begin
            cyc(1'b1, 8'hFF, 1'b0);
            chk($sformatf("ns3_sel%0d", i), int'(sel_b), (i / 2) % 3);
            chk($sformatf("ns3_en%0d", i), int'(en_b), 1);
            chk($sformatf("ns3_fd%0d", i), int'(fd_b), int'((i % 6) == 5));
        end

`ifdef SCAN_DIR_EN
        cyc(1'b0, 8'hFF, 1'b0);
        cyc(1'b1, 8'hFF, 1'b1);
        chk("dir_down_start_sel", int'(sel_a), 7);
        for (int c = 0; c < 3; c++) cyc(1'b1, 8'hFF, 1'b0);
        chk("dir_held_in_slot", int'(sel_a), 7);
        cyc(1'b1, 8'hFF, 1'b1);
        chk("dir_down_next_sel", int'(sel_a), 6);
`endif

        // Randomized traffic against the model.
        r  = 1'b1;
        mk = 8'hFF;
        dd = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 7) == 0) mk = 8'($urandom);
`ifdef SCAN_DIR_EN
            if ($urandom_range(0, 15) == 0) dd = ~dd;
`endif
            cyc(r, mk, dd);
            if ($urandom_range(0, 499) == 0) async_rst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
